conv1d_frame_ctrl: RTL and testbench
====================================

Name: conv1d_frame_ctrl

Overview:
- Frame-level sequencer for conv1d_layer.
- Clears the layer window between frames, gates the upstream sample stream into the layer for exactly frame_len samples, and joins the per-filter valid vector into one handshake.
- Discards the FILTER_SIZE-1 warm-up results and tags each emitted result vector with its output index and a last flag.
- Control only: sample data and result data bypass this block and connect directly to the layer.

Parameters:
NUM_FILTERS, 32, width of the layer valid vector
FILTER_SIZE, 5, taps per filter; sets warm-up discard count
LEN_WIDTH, 16, width of frame length, counters and output index

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  frame start request, sampled in IDLE only
frame_len  in  LEN_WIDTH  samples in frame; latched on accepted start
abort  in  1  terminate current frame
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal frame completion
err  out  1  one-cycle pulse when a start is rejected
src_valid  in  1  upstream sample valid
src_ready  out  1  upstream sample ready
layer_valid_in  out  1  sample valid to layer
layer_ready_in  in  1  layer accepts sample
layer_clear  out  1  one-cycle pulse; flushes layer window and pipeline valids
layer_valid_out  in  NUM_FILTERS  per-filter result valid
layer_ready_out  out  1  result ready to layer
dst_valid  out  1  joined result valid downstream
dst_ready  in  1  downstream ready
dst_index  out  LEN_WIDTH  output position of current result
dst_last  out  1  current result is the final one of the frame

Behaviour:
- Reset (async, immediate): state IDLE; in_cnt, out_cnt and len_q cleared. All registered outputs are 0. All gated combinational outputs are 0 because the state is IDLE.
- States: IDLE, CLEAR, RUN, DONE. State enum is conv1d_ctrl_state_t.
- IDLE:
  - abort=1: stay IDLE; abort has priority over start.
  - start=1 with frame_len < FILTER_SIZE: err=1 on the next cycle, stay IDLE.
  - start=1 otherwise: latch len_q=frame_len, go to CLEAR.
- CLEAR: layer_clear=1 for exactly one cycle. Counters zeroed. Next state is RUN, or IDLE if this CLEAR was entered from an abort.
- RUN, input side:
  - in_gate = (in_cnt < len_q).
  - layer_valid_in = src_valid & in_gate.
  - src_ready = layer_ready_in & in_gate.
  - in_cnt increments on src_valid & layer_ready_in & in_gate.
- RUN, output side:
  - all_v = &layer_valid_out. Partial valid vectors are held; they are neither consumed nor flagged.
  - discard = (out_cnt < FILTER_SIZE-1).
  - layer_ready_out = discard ? 1 : dst_ready.
  - dst_valid = all_v & ~discard.
  - A result is consumed on all_v & layer_ready_out; out_cnt then increments.
  - dst_index = out_cnt-(FILTER_SIZE-1).
  - dst_last = dst_valid & (dst_index == len_q-FILTER_SIZE).
- Layer produces one result vector per accepted sample. The controller consumes len_q vectors and emits len_q-FILTER_SIZE+1 of them.
- Input and output sides run concurrently; no stall between them beyond layer backpressure.
- The dst handshake with dst_last moves RUN to DONE. DONE drives done=1 for one cycle, then goes to IDLE.
- abort in CLEAR, RUN or DONE: next cycle enters CLEAR with the abort flag set. That CLEAR forces src_ready=0 and dst_valid=0, pulses layer_clear, then returns to IDLE. done is not asserted.
- start outside IDLE is ignored. frame_len changes after the latch have no effect.
- Outside RUN: src_ready, layer_valid_in, dst_valid and layer_ready_out are 0.
- Counters never wrap: frame_len ≤ 2^LEN_WIDTH-1.

Decomposition:
- cnn1d_pkg gains typedef enum conv1d_ctrl_state_t {IDLE, CLEAR, RUN, DONE}.
- No sub-module; the valid join is a single reduction-AND.
- Top-level integration wires this block alongside conv1d_layer, with data paths bypassing the controller.

Test Plan:
- Nominal frame: start, frame_len=8, src_valid=1, layer_ready_in=1, dst_ready=1, layer model returns all-valid 2 cycles after input.
  - Expect: one layer_clear pulse, 8 source handshakes, first 4 results discarded with dst_valid=0.
  - Expect: dst_index 0,1,2,3 with dst_last only on 3, then done one cycle later, then busy=0.
- Rejected start: start, frame_len=4. Expect err pulse the next cycle, busy stays 0, no layer_clear.
- Backpressure: frame_len=10, dst_ready toggling 1/0 each cycle. Expect layer_ready_out=dst_ready after warm-up, dst_index 0..5 each exactly once, no loss.
- Partial join: layer_valid_out=32'h7FFFFFFF for 3 cycles, then 32'hFFFFFFFF. Expect dst_valid=0 and out_cnt unchanged for 3 cycles, then one handshake.
- Abort mid-frame: abort after 6 inputs of frame_len=20.
  - Expect: next cycle src_ready=0, dst_valid=0, layer_clear=1; then IDLE, no done.
  - A following start with frame_len=5 completes with a single output, dst_index=0 and dst_last=1.
- Async reset: assert rst mid-RUN between clock edges. Expect busy, src_ready, dst_valid and layer_clear to go to 0 before the next edge, and state IDLE after release.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared types for the 1-D CNN blocks.
// Holds the frame controller state encoding.
package cnn1d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } conv1d_ctrl_state_t;

endpackage

// File: rtl/conv1d_frame_ctrl.sv
// Frame sequencer for conv1d_layer: clears the window, gates frame_len samples in,
// drops the warm-up results and tags each emitted result with index and last.
module conv1d_frame_ctrl
  import cnn1d_pkg::*;
#(
  parameter int NUM_FILTERS = 32,
  parameter int FILTER_SIZE = 5,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   layer_valid_in,
  input  logic                   layer_ready_in,
  output logic                   layer_clear,
  input  logic [NUM_FILTERS-1:0] layer_valid_out,
  output logic                   layer_ready_out,
  output logic                   dst_valid,
  input  logic                   dst_ready,
  output logic [LEN_WIDTH-1:0]   dst_index,
  output logic                   dst_last
);

  localparam logic [LEN_WIDTH-1:0] WARMUP = LEN_WIDTH'(FILTER_SIZE - 1);
  localparam logic [LEN_WIDTH-1:0] FSIZE  = LEN_WIDTH'(FILTER_SIZE);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  conv1d_ctrl_state_t state, state_nxt;
  logic                 abort_q, abort_nxt;
  logic                 err_nxt;
  logic                 latch_len;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] in_cnt;
  logic [LEN_WIDTH-1:0] out_cnt;

  logic in_run, in_gate, all_v, discard, in_inc, out_inc;

  assign in_run  = (state == RUN);
  assign in_gate = (in_cnt < len_q);
  assign all_v   = &layer_valid_out;
  assign discard = (out_cnt < WARMUP);

  assign busy        = (state != IDLE);
  assign layer_clear = (state == CLEAR);
  assign done        = (state == DONE);

  assign layer_valid_in  = in_run & src_valid & in_gate;
  assign src_ready       = in_run & layer_ready_in & in_gate;
  assign layer_ready_out = in_run & (discard | dst_ready);
  assign dst_valid       = in_run & all_v & ~discard;
  // Wraps during warm-up; only meaningful while dst_valid is high.
  assign dst_index       = out_cnt - WARMUP;
  assign dst_last        = dst_valid & (dst_index == (len_q - FSIZE));

  assign in_inc  = layer_valid_in & layer_ready_in;
  assign out_inc = in_run & all_v & layer_ready_out;

  always_comb begin
    state_nxt = state;
    abort_nxt = abort_q;
    err_nxt   = 1'b0;
    latch_len = 1'b0;
    case (state)
      IDLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          if (frame_len < FSIZE) begin
            err_nxt = 1'b1;
          end else begin
            latch_len = 1'b1;
            abort_nxt = 1'b0;
            state_nxt = CLEAR;
          end
        end
      end
      CLEAR: begin
        if (abort) begin
          abort_nxt = 1'b1;
          state_nxt = CLEAR;
        end else if (abort_q) begin
          abort_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          abort_nxt = 1'b1;
          state_nxt = CLEAR;
        end else if (dst_valid & dst_ready & dst_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          abort_nxt = 1'b1;
          state_nxt = CLEAR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      abort_q <= 1'b0;
      err     <= 1'b0;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_nxt;
      err     <= err_nxt;
      if (latch_len) len_q <= frame_len;
      if (state == CLEAR) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_inc)  in_cnt  <= in_cnt + 1'b1;
        if (out_inc) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_frame_ctrl.sv
// Directed bench for conv1d_frame_ctrl with a small layer latency model
// and a scoreboard of expected {last, index} results.
module tb_conv1d_frame_ctrl;
  localparam int NF = 32;
  localparam int FS = 5;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          abort;
  logic          busy, done, err;
  logic          src_valid, src_ready;
  logic          layer_valid_in, layer_ready_in, layer_clear;
  logic [NF-1:0] layer_valid_out;
  logic          layer_ready_out;
  logic          dst_valid, dst_ready, dst_last;
  logic [LW-1:0] dst_index;

  always #5 clk = ~clk;

  conv1d_frame_ctrl #(.NUM_FILTERS(NF), .FILTER_SIZE(FS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready),
    .layer_valid_in(layer_valid_in), .layer_ready_in(layer_ready_in),
    .layer_clear(layer_clear), .layer_valid_out(layer_valid_out),
    .layer_ready_out(layer_ready_out),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_index(dst_index), .dst_last(dst_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dst_ready source: fixed level or a 1/0 toggle every cycle.
  logic dst_rdy_drv, tog_en, tog;
  always @(negedge clk) if (tog_en) tog <= ~tog; else tog <= 1'b1;
  assign dst_ready = tog_en ? tog : dst_rdy_drv;

  // Layer model: result vector becomes all-valid two cycles after its sample.
  logic          man_en;
  logic [NF-1:0] man_lvo;
  int            avail;
  logic          d1;
  assign layer_valid_out = man_en ? man_lvo : ((avail > 0) ? '1 : '0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      avail <= 0;
      d1    <= 1'b0;
    end else if (layer_clear) begin
      avail <= 0;
      d1    <= 1'b0;
    end else begin
      d1    <= layer_valid_in & layer_ready_in;
      avail <= avail + int'(d1)
               - int'(!man_en && (&layer_valid_out) && layer_ready_out);
    end
  end

  // Monitor: event counters and observed result queue.
  int cyc = 0, clear_cnt = 0, src_hs = 0, disc_cnt = 0;
  int done_cnt = 0, err_cnt = 0, bp_mis = 0, last_hs_cyc = 0, done_cyc = 0;
  logic [LW:0] exp_q[$];
  logic [LW:0] obs_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (layer_clear) clear_cnt <= clear_cnt + 1;
      if (src_valid && src_ready) src_hs <= src_hs + 1;
      if ((&layer_valid_out) && layer_ready_out && !dst_valid) disc_cnt <= disc_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (err) err_cnt <= err_cnt + 1;
      if (dst_valid && (layer_ready_out != dst_ready)) bp_mis <= bp_mis + 1;
      if (dst_valid && dst_ready) begin
        obs_q.push_back({dst_last, dst_index});
        if (dst_last) last_hs_cyc <= cyc;
      end
    end
  end

  task automatic push_frame(input int len);
    for (int i = 0; i <= len - FS; i++)
      exp_q.push_back({(i == len - FS) ? 1'b1 : 1'b0, LW'(i)});
  endtask

  task automatic compare_frame(input string tag);
    logic [LW:0] o, e;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_index"}, o[LW-1:0], e[LW-1:0]);
      check_val({tag, "_last"}, o[LW], e[LW]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    frame_len = LW'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_len = 16'd3;
  endtask

  task automatic wait_done(input string tag, input int base);
    for (int i = 0; i < 400 && done_cnt == base; i++) @(negedge clk);
    check_val({tag, "_done"}, done_cnt - base, 1);
  endtask

  int b_clr, b_hs, b_disc, b_done, b_err, b_bp;

  task automatic snap();
    b_clr = clear_cnt; b_hs = src_hs; b_disc = disc_cnt;
    b_done = done_cnt; b_err = err_cnt; b_bp = bp_mis;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_len = '0; abort = 1'b0;
    src_valid = 1'b1; layer_ready_in = 1'b1; dst_rdy_drv = 1'b1;
    tog_en = 1'b0; man_en = 1'b0; man_lvo = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_clear", layer_clear, 0);
    check_val("rst_src_ready", src_ready, 0);
    check_val("rst_dst_valid", dst_valid, 0);
    check_val("rst_lro", layer_ready_out, 0);
    rst = 1'b0;

    // Nominal frame of 8 samples.
    snap();
    push_frame(8);
    start_frame(8);
    wait_done("nom", b_done);
    check_val("nom_clear", clear_cnt - b_clr, 1);
    check_val("nom_src_hs", src_hs - b_hs, 8);
    check_val("nom_discard", disc_cnt - b_disc, 4);
    check_val("nom_done_lat", done_cyc - last_hs_cyc, 1);
    check_val("nom_busy_after", busy, 0);
    compare_frame("nom");

    // Rejected start: frame_len below the filter size.
    snap();
    @(negedge clk);
    frame_len = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("rej_err", err, 1);
    check_val("rej_busy", busy, 0);
    @(negedge clk);
    check_val("rej_err_pulse", err, 0);
    check_val("rej_busy2", busy, 0);
    check_val("rej_clear", clear_cnt - b_clr, 0);
    check_val("rej_err_cnt", err_cnt - b_err, 1);

    // Downstream backpressure toggling every cycle.
    snap();
    tog_en = 1'b1;
    push_frame(10);
    start_frame(10);
    wait_done("bp", b_done);
    tog_en = 1'b0;
    check_val("bp_follow", bp_mis - b_bp, 0);
    check_val("bp_src_hs", src_hs - b_hs, 10);
    check_val("bp_discard", disc_cnt - b_disc, 4);
    compare_frame("bp");

    // Partial valid vector is held without consuming.
    snap();
    man_en = 1'b1;
    man_lvo = '0;
    start_frame(5);
    @(negedge clk);
    man_lvo = '1;
    repeat (4) @(negedge clk);
    man_lvo = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("part_dst_valid", dst_valid, 0);
      check_val("part_index", dst_index, 0);
      @(negedge clk);
    end
    check_val("part_discard", disc_cnt - b_disc, 4);
    man_lvo = '1;
    #1;
    check_val("join_dst_valid", dst_valid, 1);
    check_val("join_last", dst_last, 1);
    exp_q.push_back({1'b1, 16'd0});
    @(negedge clk);
    man_lvo = '0;
    wait_done("part", b_done);
    man_en = 1'b0;
    compare_frame("part");

    // Abort after 6 inputs of a 20-sample frame.
    snap();
    dst_rdy_drv = 1'b0;
    start_frame(20);
    for (int i = 0; i < 100 && (src_hs - b_hs) < 6; i++) @(negedge clk);
    check_val("abort_inputs", src_hs - b_hs, 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_src_ready", src_ready, 0);
    check_val("abort_dst_valid", dst_valid, 0);
    check_val("abort_clear", layer_clear, 1);
    @(negedge clk);
    check_val("abort_idle", busy, 0);
    check_val("abort_clear_off", layer_clear, 0);
    repeat (3) @(negedge clk);
    check_val("abort_no_done", done_cnt - b_done, 0);
    check_val("abort_no_out", obs_q.size(), 0);
    dst_rdy_drv = 1'b1;
    snap();
    push_frame(5);
    start_frame(5);
    wait_done("post_abort", b_done);
    check_val("post_abort_discard", disc_cnt - b_disc, 4);
    compare_frame("post_abort");

    // Asynchronous reset in the middle of RUN.
    snap();
    exp_q.push_back({1'b0, 16'd0});
    exp_q.push_back({1'b0, 16'd1});
    start_frame(20);
    for (int i = 0; i < 100 && obs_q.size() < 2; i++) @(negedge clk);
    check_val("pre_rst_dst_valid", dst_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_src_ready", src_ready, 0);
    check_val("arst_dst_valid", dst_valid, 0);
    check_val("arst_clear", layer_clear, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_idle", busy, 0);
    check_val("arst_no_done", done_cnt - b_done, 0);
    compare_frame("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
